// File: rtl/dmem_resp.sv
// dmem_resp: data-memory slave for the core's dm_* port.
// One request per cycle, fixed one-cycle registered read latency, write-first
// read-during-write, per-bit write mask. Out-of-range accesses are dropped,
// read as zero and raise a sticky error flag.
// Optional feature macro: DMEM_MMIO_EN adds a 16-byte MMIO window at MMIO_BASE
// with TOHOST (R/W), CYCLE (RO), CONSOLE (WO) and a reserved slot.
module dmem_resp #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wen_i,
    input  logic [31:0] dm_din_i,
    output logic [31:0] dm_dout_o,
    output logic        err_o,
    output logic [31:0] tohost_o,
    output logic        done_o,
    output logic        console_valid_o,
    output logic [7:0]  console_data_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Word array; contents deliberately have no reset.
    logic [31:0] mem_q [DEPTH];

    // 33-bit subtraction so an address below BASE_ADDR shows up as a borrow
    // instead of wrapping back into the array.
    logic [32:0]   diff;
    logic          below;
    logic [29:0]   word_off;
    logic          in_range;
    logic [AW-1:0] idx;

    assign diff     = {1'b0, dm_addr_i} - {1'b0, BASE_ADDR};
    assign below    = diff[32];
    assign word_off = diff[31:2];
    assign in_range = !below && (word_off < 30'(DEPTH));
    assign idx      = diff[AW+1:2];

    // Byte-offset bits are ignored by design; MMIO_BASE low bits are fixed by alignment.
    logic unused_cfg;
    assign unused_cfg = ^{diff[1:0], MMIO_BASE};

    logic        wr;
    logic [31:0] mem_rd;
    logic [31:0] mem_mrg;
    logic        mem_we;
    logic [31:0] dout_d, dout_q;
    logic        err_d, err_q;

    assign wr      = |dm_wen_i;
    assign mem_rd  = mem_q[idx];
    assign mem_mrg = (mem_rd & ~dm_wen_i) | (dm_din_i & dm_wen_i);

`ifdef DMEM_MMIO_EN
    logic        mmio_hit;
    logic [31:0] th_mrg;
    logic [31:0] tohost_d, tohost_q;
    logic        done_d, done_q;
    logic        cvalid_d, cvalid_q;
    logic [7:0]  cdata_d, cdata_q;
    logic [31:0] cyc_q;

    assign mmio_hit = (dm_addr_i[31:4] == MMIO_BASE[31:4]);
    assign th_mrg   = (tohost_q & ~dm_wen_i) | (dm_din_i & dm_wen_i);
`endif

    // Request decode: MMIO window first (when built in), then array range check.
    always_comb begin
        dout_d = '0;
        mem_we = 1'b0;
        err_d  = err_q;
`ifdef DMEM_MMIO_EN
        tohost_d = tohost_q;
        done_d   = done_q;
        cvalid_d = 1'b0;
        cdata_d  = cdata_q;
        if (mmio_hit) begin
            case (dm_addr_i[3:2])
                2'd0: begin
                    // th_mrg equals tohost_q on a read, so write-first falls out.
                    dout_d = th_mrg;
                    if (wr) begin
                        tohost_d = th_mrg;
                        if (th_mrg != '0) done_d = 1'b1;
                    end
                end
                2'd1: dout_d = cyc_q;
                2'd2: begin
                    if (|dm_wen_i[7:0]) begin
                        cvalid_d = 1'b1;
                        cdata_d  = dm_din_i[7:0];
                    end
                end
                default: err_d = 1'b1;
            endcase
        end else
`endif
        if (in_range) begin
            mem_we = wr;
            dout_d = mem_mrg;
        end else begin
            err_d = 1'b1;
        end
    end

    // Array write port; merge already computed on the read side.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[idx] <= mem_mrg;
    end

    // Response and sticky error registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dout_q <= '0;
            err_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            err_q  <= err_d;
        end
    end

    assign dm_dout_o = dout_q;
    assign err_o     = err_q;

`ifdef DMEM_MMIO_EN
    // MMIO state: TOHOST, done flag and console strobe/data.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tohost_q <= '0;
            done_q   <= 1'b0;
            cvalid_q <= 1'b0;
            cdata_q  <= '0;
        end else begin
            tohost_q <= tohost_d;
            done_q   <= done_d;
            cvalid_q <= cvalid_d;
            cdata_q  <= cdata_d;
        end
    end

    // Free-running cycle counter, wraps naturally at 32 bits.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cyc_q <= '0;
        else          cyc_q <= cyc_q + 32'd1;
    end

    assign tohost_o        = tohost_q;
    assign done_o          = done_q;
    assign console_valid_o = cvalid_q;
    assign console_data_o  = cdata_q;
`else
    assign tohost_o        = '0;
    assign done_o          = 1'b0;
    assign console_valid_o = 1'b0;
    assign console_data_o  = '0;
`endif

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Data-memory responder: the slave end of the core's dm_* interface.
- Accepts one access per cycle: word address, 32-bit per-bit write mask, write data.
- Returns read data with fixed one-cycle latency.
- Backs a synchronous word array; optionally decodes a small MMIO window used by sim/FPGA tops for test termination and console output.

Parameters:
DEPTH, 1024, number of 32-bit words in the array; power of two, at least 4
BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to 4*DEPTH
MMIO_BASE, 32'h8000_0000, byte base of the MMIO window; 16-byte aligned; only used when DMEM_MMIO_EN is defined

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
dm_addr_i  in  32  byte address from core; bits [1:0] ignored
dm_wen_i  in  32  per-bit write mask; any bit set = write cycle, all zero = read cycle
dm_din_i  in  32  write data
dm_dout_o  out  32  read data, registered, valid the cycle after the request
err_o  out  1  sticky: an out-of-range access occurred
tohost_o  out  32  last value written to TOHOST
done_o  out  1  sticky: nonzero TOHOST write seen
console_valid_o  out  1  one-cycle strobe on CONSOLE write
console_data_o  out  8  byte written to CONSOLE, valid with the strobe

Behaviour:
- Reset is asynchronous and active-low on rst_n_i, single clock clk_i.
- Reset values: dm_dout_o=0, err_o=0, tohost_o=0, done_o=0, console_valid_o=0, console_data_o=0, cycle counter=0.
- Array contents are not reset.
- Every cycle is a request; there is no valid/ready handshake and no stall.
- Word index: idx = (dm_addr_i - BASE_ADDR) >> 2.
- In range: dm_addr_i >= BASE_ADDR and idx < DEPTH.
- Write (dm_wen_i != 0), in range, at edge N: mem[idx] <= (mem[idx] & ~dm_wen_i) | (dm_din_i & dm_wen_i).
- Read path is evaluated on every request, including write cycles:
  - At edge N, dm_dout_o <= word at idx.
  - Write-first: if the same request writes that word, dm_dout_o carries the post-merge value.
- Back-to-back write to A at cycle N followed by read of A at cycle N+1: the read returns the new data (no hazard).
- Out-of-range access (not array, not an enabled MMIO register):
  - Write is dropped.
  - dm_dout_o <= 0.
  - err_o <= 1, held until reset.
- Misaligned addresses: low two bits are silently dropped; no error.
- Address arithmetic is 32-bit unsigned; an address below BASE_ADDR is out of range (no wrap into the array).
- Reset asserted mid-access: the in-flight write may or may not land; outputs return to reset values immediately.

Optional Feature:
Macro DMEM_MMIO_EN.
- Defined: the 16-byte window at MMIO_BASE is decoded ahead of the array range check.
  - +0x0 TOHOST, R/W:
    - Write: tohost_o <= masked merge with current tohost_o.
    - If the merged value != 0, done_o <= 1 (sticky).
    - Read returns tohost_o.
  - +0x4 CYCLE, RO:
    - 32-bit free-running counter, +1 every cycle after reset release, wraps 0xFFFF_FFFF -> 0.
    - Read returns the value at the request edge.
    - Writes are ignored, no err.
  - +0x8 CONSOLE, WO:
    - Write with any of dm_wen_i[7:0] set: console_valid_o=1 for exactly the next cycle, console_data_o=dm_din_i[7:0].
    - Read returns 0.
  - +0xC: reserved; reads return 0, writes ignored, err_o set.
- Not defined:
  - No decode, no counter logic.
  - tohost_o, done_o, console_valid_o, console_data_o tied to 0.
  - MMIO_BASE addresses follow the normal range rule (err if outside the array).

Test Plan:
- Full-mask write 0xDEAD_BEEF to 0x10, then read 0x10 -> dm_dout_o=0xDEAD_BEEF one cycle after the read request; err_o=0.
- Write 0xFFFF_FFFF to 0x20, then write 0x0000_0012 with mask 0x0000_00FF to 0x20, then read 0x20 -> 0xFFFF_FF12.
- Same-cycle write-first: write 0x1234_5678 to 0x40 with mask 0xFFFF_FFFF -> dm_dout_o=0x1234_5678 next cycle. Next-cycle read of 0x40 -> 0x1234_5678.
- Read at BASE_ADDR+4*DEPTH, e.g. 0x1000 with DEPTH=1024 -> dm_dout_o=0, err_o=1 and stays 1; an out-of-range write leaves all array words unchanged.
- DMEM_MMIO_EN:
  - Write 0x41 to 0x8000_0008 -> console_valid_o high for one cycle with console_data_o=0x41.
  - Write 1 to 0x8000_0000 -> tohost_o=1, done_o=1.
  - Two CYCLE reads k cycles apart differ by k.
- Assert rst_n_i asynchronously mid-run after done_o/err_o are set -> all outputs 0 without waiting for a clock edge. After release, CYCLE read in the first cycle returns a small value (< 3).
